seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the board's 4-digit common-anode 7-segment display.
//  The MCS firmware (via GPO) or fabric logic posts a 16-bit hex value, a blank mask and a dp mask.
//  The block refreshes one digit per slot, inserts anti-ghosting blanking, and applies updates
//  only at frame boundaries, so the display never tears.
// PARAMETERS
//  DIGIT_CYCLES  50000  clk cycles per digit slot (1 ms @ 50 MHz); must be >= 2
//  BLANK_CYCLES  500    cycles at slot start with all anodes off; must be < DIGIT_CYCLES
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst_n       in   1   synchronous active-low reset
//  wr_en       in   1   write strobe; captures wr_data/wr_blank/wr_dp into the pending register
//  wr_data     in   16  hex value; digit i = wr_data[4i+3:4i], digit 0 rightmost
//  wr_blank    in   4   1 = digit i dark
//  wr_dp       in   4   1 = decimal point i lit
//  wr_busy     out  1   pending update not yet applied
//  wr_ack      out  1   1-cycle pulse: pending update transferred to the active set
//  frame_tick  out  1   1-cycle pulse on the last cycle of every frame
//  seg         out  7   [0:6] = a..g, active-low
//  dp          out  1   decimal point, active-low
//  an          out  4   [0:3] anodes, active-low; digit i drives an[3-i]
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): cnt=0, idx=0, active value=0, active blank=4'b1111, active dp=0,
//   pend_valid=0. Outputs: an=4'b1111, seg=7'b1111111, dp=1, wr_busy=0, wr_ack=0, frame_tick=0.
//   Reset asserted mid-frame aborts the frame and discards any pending write.
//  Timing: cnt runs 0..DIGIT_CYCLES-1, then wraps to 0 and idx increments; idx wraps 3->0.
//   Frame = 4 slots = 4*DIGIT_CYCLES cycles. Boundary cycle: idx==3 && cnt==DIGIT_CYCLES-1.
//  Slot FSM, per slot: BLANK (cnt < BLANK_CYCLES) -> DRIVE (remaining cycles) -> next slot's BLANK.
//   BLANK: an=1111, seg=1111111, dp=1.
//   DRIVE: an[3-idx]=0, other anodes 1; seg=hex code of active nibble idx; dp=~active_dp[idx].
//   If active_blank[idx]=1, the whole slot behaves as BLANK.
//  Outputs are registered: pins reflect (cnt,idx) state with 1-cycle latency.
//  Hex codes, abcdefg active-low:
//   0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111
//   8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000
//  Write path:
//   wr_en=1 loads pending regs and sets pend_valid; wr_busy = pend_valid (registered).
//   Writes while busy overwrite pending; last write wins. No write is ever rejected.
//  Boundary cycle:
//   frame_tick=1 on the next cycle.
//   If pend_valid, the active set takes pending, pend_valid clears and wr_ack=1 on the next cycle.
//   New active values display from slot 0 of the next frame.
//  wr_en on the boundary cycle:
//   The pre-existing pending set (if any) transfers.
//   The new write becomes pending (pend_valid stays 1, applied next frame).
//   If nothing was pending, no transfer occurs and no ack is issued; the write waits one frame.
//  wr_ack never pulses without a preceding write.
//  An idle controller (no writes) scans forever with no acks.
// TESTING  (bench params DIGIT_CYCLES=8, BLANK_CYCLES=2)
//  1. rst_n=0 for 2 cycles, then release -> an=1111, seg=1111111, dp=1, wr_busy=0; no anode
//     goes low for a full frame (all blanked).
//  2. Write 16'h1A3F, blank=0000, dp=0010 at idx=0 -> wr_busy=1 until wr_ack (cycle 32 after
//     frame start). Next frame: slot0 an=1110 seg=0111000; slot1 an=1101 seg=0000110 dp=0;
//     slot2 an=1011 seg=0001000; slot3 an=0111 seg=1001111.
//  3. Steady scan -> every slot shows exactly 2 cycles of an=1111 before 6 cycles of one low
//     anode; frame_tick period = 32.
//  4. Writes 16'h1111 then 16'h2222 mid-frame -> one wr_ack only; all digits show 0010010.
//  5. Writes on the boundary cycle, with and without a prior pending write -> transfer/ack
//     behave exactly as specified above.
//  6. Write, then rst_n=0 at slot2 -> pending discarded, no wr_ack, display back to reset
//     state; blank=1000 hides only digit 3 (an[0] never low).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode 7-segment scanner with anti-ghost blanking
// and frame-aligned double-buffered updates.
module seg7_scan_ctrl #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [15:0] i_wr_data,
    input  logic [3:0]  i_wr_blank,
    input  logic [3:0]  i_wr_dp,
    output logic        o_wr_busy,
    output logic        o_wr_ack,
    output logic        o_frame_tick,
    output logic [0:6]  o_seg,
    output logic        o_dp,
    output logic [0:3]  o_an
);
    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    typedef enum logic {BLANK, DRIVE} phase_t;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_act_data, r_pend_data;
    logic [3:0]    r_act_blank, r_act_dp, r_pend_blank, r_pend_dp;
    logic          r_pend_valid, r_ack, r_tick, r_dp;
    logic [0:6]    r_seg;
    logic [0:3]    r_an;
    logic          w_last, w_bnd;
    logic [3:0]    w_nib;
    logic [0:6]    w_hex;
    logic [0:3]    w_an;
    phase_t        w_phase;

    function automatic logic [0:6] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        w_last  = r_cnt == CW'(DIGIT_CYCLES - 1);
        w_bnd   = w_last && r_idx == 2'd3;
        w_nib   = r_act_data[{r_idx, 2'b00} +: 4];
        w_hex   = hex7(w_nib);
        w_phase = (r_cnt < CW'(BLANK_CYCLES) || r_act_blank[r_idx]) ? BLANK : DRIVE;
        w_an    = 4'b1111;
        w_an[~r_idx] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_blank  <= 4'b1111;
            r_act_dp     <= '0;
            r_pend_data  <= '0;
            r_pend_blank <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_ack        <= 1'b0;
            r_tick       <= 1'b0;
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
        end else begin
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            r_idx  <= w_last ? r_idx + 1'b1 : r_idx;
            r_tick <= w_bnd;
            r_ack  <= w_bnd && r_pend_valid;
            // Transfer sees the pending set from before any same-cycle write.
            if (w_bnd && r_pend_valid) begin
                r_act_data  <= r_pend_data;
                r_act_blank <= r_pend_blank;
                r_act_dp    <= r_pend_dp;
            end
            if (i_wr_en) begin
                r_pend_data  <= i_wr_data;
                r_pend_blank <= i_wr_blank;
                r_pend_dp    <= i_wr_dp;
                r_pend_valid <= 1'b1;
            end else if (w_bnd) begin
                r_pend_valid <= 1'b0;
            end
            r_an  <= (w_phase == DRIVE) ? w_an : 4'b1111;
            r_seg <= (w_phase == DRIVE) ? w_hex : 7'b1111111;
            r_dp  <= (w_phase == DRIVE) ? ~r_act_dp[r_idx] : 1'b1;
        end
    end

    assign o_wr_busy    = r_pend_valid;
    assign o_wr_ack     = r_ack;
    assign o_frame_tick = r_tick;
    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_an         = r_an;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random stimulus against a time-index model
// of the scanner (position derived from cycles since reset).
module tb_seg7_scan_ctrl;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_blank = '0;
    logic [3:0]  wr_dp = '0;
    logic        wr_busy, wr_ack, frame_tick, dp;
    logic [0:6]  seg;
    logic [0:3]  an;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int          m_t;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_blank, m_dp, p_blank, p_dp;
    logic        p_valid;

    seg7_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_wr_blank(wr_blank), .i_wr_dp(wr_dp), .o_wr_busy(wr_busy), .o_wr_ack(wr_ack),
        .o_frame_tick(frame_tick), .o_seg(seg), .o_dp(dp), .o_an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at t=%0d: observed %h expected %h", tag, m_t, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic [15:0] d,
                       input logic [3:0] b, input logic [3:0] p);
        int cnt, idx;
        logic bnd, drv;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_tick, e_ack, e_busy;
        cnt = m_t % DC;
        idx = (m_t / DC) % 4;
        bnd = (m_t % FRAME) == FRAME - 1;
        drv = !rst && cnt >= BC && !m_blank[idx];
        e_an   = drv ? ~(4'b0001 << idx) : 4'b1111;
        e_seg  = drv ? hex_tab[(m_val >> (4 * idx)) & 16'hF] : 7'b1111111;
        e_dp   = drv ? ~m_dp[idx] : 1'b1;
        e_tick = !rst && bnd;
        e_ack  = !rst && bnd && p_valid;
        if (rst) begin
            m_t = 0; m_val = '0; m_blank = 4'hF; m_dp = '0; p_valid = 1'b0;
        end else begin
            if (bnd && p_valid) begin
                m_val = p_val; m_blank = p_blank; m_dp = p_dp;
            end
            if (en) begin
                p_val = d; p_blank = b; p_dp = p; p_valid = 1'b1;
            end else if (bnd) begin
                p_valid = 1'b0;
            end
            m_t++;
        end
        e_busy = p_valid;
        rst_n = ~rst; wr_en = en; wr_data = d; wr_blank = b; wr_dp = p;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("an", 16'(an), 16'(e_an));
        chk("seg", 16'(seg), 16'(e_seg));
        chk("dp", 16'(dp), 16'(e_dp));
        chk("frame_tick", 16'(frame_tick), 16'(e_tick));
        chk("wr_ack", 16'(wr_ack), 16'(e_ack));
        chk("wr_busy", 16'(wr_busy), 16'(e_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_to(input int ph);
        for (int i = 0; i < FRAME && (m_t % FRAME) != ph; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    initial begin
        m_t = 0; m_val = '0; m_blank = 4'hF; m_dp = '0;
        p_val = '0; p_blank = '0; p_dp = '0; p_valid = 1'b0;
        // Reset, then one frame fully dark.
        cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(FRAME);
        // Write at slot 0, observe ack and two full frames.
        cyc(1'b0, 1'b1, 16'h1A3F, 4'b0000, 4'b0010);
        idle(3 * FRAME);
        // Two writes mid-frame: one ack, last value wins.
        idle_to(5);
        cyc(1'b0, 1'b1, 16'h1111, 4'h0, 4'h0);
        idle(3);
        cyc(1'b0, 1'b1, 16'h2222, 4'h0, 4'h0);
        idle(2 * FRAME);
        // Boundary write with nothing pending: waits a frame.
        idle_to(FRAME - 1);
        cyc(1'b0, 1'b1, 16'hC0DE, 4'h0, 4'b0101);
        idle(2 * FRAME);
        // Boundary write with a prior pending write.
        idle_to(10);
        cyc(1'b0, 1'b1, 16'h4567, 4'b0010, 4'h0);
        idle_to(FRAME - 1);
        cyc(1'b0, 1'b1, 16'h89AB, 4'h0, 4'b1000);
        idle(2 * FRAME);
        // Reset during slot 2 discards pending write.
        idle_to(3);
        cyc(1'b0, 1'b1, 16'hEEEE, 4'h0, 4'h0);
        idle_to(2 * DC + 1);
        cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(2 * FRAME);
        // Blank mask hides only digit 3.
        cyc(1'b0, 1'b1, 16'h8D5B, 4'b1000, 4'b1111);
        idle(3 * FRAME);
        // Random writes.
        for (int i = 0; i < 600; i++)
            cyc(1'b0, $urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
        idle(2 * FRAME);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
